jk_bank_sequencer: RTL and testbench

JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

---
 rtl/jk_bank_sequencer.sv | 171 +++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// Sequences a bank of external JK flip-flops: clear/set/load/toggle and
// multi-step up/down counting, with registered J/K drive pulses.
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_steps,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SETTLE,
    DONE
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [3:0]       steps_r;
  logic             wrap_pend;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] data_sel;
  logic [WIDTH-1:0] nj;
  logic [WIDTH-1:0] nk;
  logic             nwrap;
  logic             is_cnt;
  logic             direct;

  // Bit i toggles when all lower bits would carry (up) or borrow (down).
  function automatic logic [WIDTH-1:0] carry_mask(
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] m;
    m[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      m[i] = m[i-1] & v[i-1];
    end
    return m;
  endfunction

  assign cmd_ready = (state == IDLE);

  assign op_sel   = (state == IDLE) ? cmd : op_r;
  assign data_sel = (state == IDLE) ? cmd_data : data_r;

  assign is_cnt = (op_r == OP_UP) || (op_r == OP_DOWN);

  assign direct = (cmd == OP_NOP) || (cmd == OP_RSVD) ||
                  (((cmd == OP_UP) || (cmd == OP_DOWN)) &&
                   (cmd_steps == 4'd0));

  always_comb begin
    nj    = '0;
    nk    = '0;
    nwrap = 1'b0;
    unique case (op_sel)
      OP_CLEAR: nk = ONES;
      OP_SET:   nj = ONES;
      OP_LOAD: begin
        nj = data_sel;
        nk = ~data_sel;
      end
      OP_TOGGLE: begin
        nj = data_sel;
        nk = data_sel;
      end
      OP_UP: begin
        nj    = carry_mask(q_in);
        nk    = nj;
        nwrap = (q_in == ONES);
      end
      OP_DOWN: begin
        nj    = carry_mask(~q_in);
        nk    = nj;
        nwrap = (q_in == '0);
      end
      default: begin
        nj = '0;
        nk = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= OP_NOP;
      data_r    <= '0;
      steps_r   <= '0;
      wrap_pend <= 1'b0;
      j         <= '0;
      k         <= '0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      j    <= '0;
      k    <= '0;
      done <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r    <= cmd;
            data_r  <= cmd_data;
            steps_r <= cmd_steps;
            if (direct) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= (cmd == OP_RSVD);
            end else begin
              state     <= APPLY;
              j         <= nj;
              k         <= nk;
              wrap_pend <= nwrap;
            end
          end
        end
        APPLY: begin
          state <= SETTLE;
          wrap  <= wrap_pend;
        end
        SETTLE: begin
          if (is_cnt) begin
            steps_r <= steps_r - 4'd1;
          end
          // Next step's drive is taken from the settled bank value.
          if (is_cnt && (steps_r != 4'd1)) begin
            state     <= APPLY;
            j         <= nj;
            k         <= nk;
            wrap_pend <= nwrap;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer: directed scenarios plus
// randomized commands against an arithmetic model of the bank value.
module tb_jk_bank_sequencer;

  localparam int W = 4;
  localparam logic [W-1:0] M = '1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd = '0;
  logic [W-1:0] cmd_data = '0;
  logic [3:0]   cmd_steps = '0;
  logic [W-1:0] q = '0;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         done;
  logic         wrap;
  logic         err;

  int n_tests = 0;
  int n_fail = 0;

  int           r_done_cyc;
  int           r_wrap_cyc;
  int           r_wraps;
  int           r_drive;
  logic         r_err;
  logic         r_ready_after;
  logic [W-1:0] r_j1;
  logic [W-1:0] r_k1;
  logic [W-1:0] r_j3;
  logic [W-1:0] r_q2;
  logic [W-1:0] r_qf;

  always #5 clk = ~clk;

  // External JK flip-flop bank.
  always @(posedge clk) q <= (j & ~q) | (~k & q);

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd(cmd),
    .cmd_data(cmd_data),
    .cmd_steps(cmd_steps),
    .q_in(q),
    .j(j),
    .k(k),
    .done(done),
    .wrap(wrap),
    .err(err)
  );

  function automatic logic [W-1:0] m_q(
    input logic [2:0] c, input logic [W-1:0] d,
    input int s, input logic [W-1:0] q0
  );
    case (c)
      3'd1: return '0;
      3'd2: return M;
      3'd3: return d;
      3'd4: return q0 ^ d;
      3'd5: return W'((int'(q0) + s) % (1 << W));
      3'd6: return W'((int'(q0) - s + 16 * (1 << W)) % (1 << W));
      default: return q0;
    endcase
  endfunction

  function automatic int m_wraps(
    input logic [2:0] c, input int s, input logic [W-1:0] q0
  );
    int n = 0;
    for (int i = 0; i < s; i++) begin
      if (c == 3'd5 && m_q(3'd5, '0, i, q0) == M) n++;
      if (c == 3'd6 && m_q(3'd6, '0, i, q0) == '0) n++;
    end
    return n;
  endfunction

  function automatic int m_cyc(input logic [2:0] c, input int s);
    if (c == 3'd0 || c == 3'd7) return 1;
    if (c == 3'd5 || c == 3'd6) return (s == 0) ? 1 : 2 * s + 1;
    return 3;
  endfunction

  function automatic int m_drive(
    input logic [2:0] c, input logic [W-1:0] d, input int s
  );
    if (c == 3'd5 || c == 3'd6) return s;
    if (c == 3'd4) return (d != '0) ? 1 : 0;
    if (c >= 3'd1 && c <= 3'd3) return 1;
    return 0;
  endfunction

  // Offers one command at a negedge and watches it to completion.
  task automatic issue(
    input logic [2:0] c, input logic [W-1:0] d, input logic [3:0] s
  );
    int  cyc = 0;
    bit  seen = 0;
    r_wraps = 0; r_drive = 0; r_err = 1'b0;
    r_done_cyc = -1; r_wrap_cyc = -1;
    cmd_valid = 1'b1; cmd = c; cmd_data = d; cmd_steps = s;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      cmd = 3'($urandom);
      cmd_data = W'($urandom);
      cmd_steps = 4'($urandom);
      if (cyc == 1) begin r_j1 = j; r_k1 = k; end
      if (cyc == 2) r_q2 = q;
      if (cyc == 3) r_j3 = j;
      if ((j | k) != '0) r_drive++;
      if (wrap) begin
        r_wraps++;
        if (r_wrap_cyc < 0) r_wrap_cyc = cyc;
      end
      if (done) begin seen = 1; r_done_cyc = cyc; r_err = err; end
    end
    @(negedge clk);
    r_ready_after = cmd_ready;
    r_qf = q;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, j, k, done, wrap, err} !== {1'b1, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b j=%h k=%h d=%b w=%b e=%b want 1 0 0 0 0 0",
               cmd_ready, j, k, done, wrap, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    issue(3'd1, '0, 4'd0);
    issue(3'd3, 4'b1010, 4'd0);
    n_tests++;
    if ({r_j1, r_k1} !== 8'b1010_0101) begin
      n_fail++;
      $display("FAIL load_jk: got j=%b k=%b want 1010 0101", r_j1, r_k1);
    end
    n_tests++;
    if (r_q2 !== 4'b1010) begin
      n_fail++;
      $display("FAIL load_q_settle: got %b want 1010", r_q2);
    end
    n_tests++;
    if (r_done_cyc !== 3) begin
      n_fail++;
      $display("FAIL load_done_cyc: got %0d want 3", r_done_cyc);
    end
    n_tests++;
    if (r_ready_after !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready_c4: got %b want 1", r_ready_after);
    end
  endtask

  task automatic test_up_wrap();
    issue(3'd3, 4'b1110, 4'd0);
    issue(3'd5, '0, 4'd3);
    n_tests++;
    if (r_j1 !== 4'b0001) begin
      n_fail++;
      $display("FAIL up_j1: got %b want 0001", r_j1);
    end
    n_tests++;
    if (r_done_cyc !== 7) begin
      n_fail++;
      $display("FAIL up_done_cyc: got %0d want 7", r_done_cyc);
    end
    n_tests++;
    if (r_wraps !== 1 || r_wrap_cyc !== 4) begin
      n_fail++;
      $display("FAIL up_wrap: got n=%0d at %0d want 1 at 4", r_wraps, r_wrap_cyc);
    end
    n_tests++;
    if (r_qf !== 4'b0001) begin
      n_fail++;
      $display("FAIL up_q: got %b want 0001", r_qf);
    end
  endtask

  task automatic test_down_wrap();
    issue(3'd3, 4'b0001, 4'd0);
    issue(3'd6, '0, 4'd2);
    n_tests++;
    if (r_j1 !== 4'b0001 || r_j3 !== 4'b1111) begin
      n_fail++;
      $display("FAIL down_j: got %b,%b want 0001,1111", r_j1, r_j3);
    end
    n_tests++;
    if (r_done_cyc !== 5 || r_wraps !== 1) begin
      n_fail++;
      $display("FAIL down_done_wrap: got cyc=%0d w=%0d want 5 1", r_done_cyc, r_wraps);
    end
    n_tests++;
    if (r_qf !== 4'b1111) begin
      n_fail++;
      $display("FAIL down_q: got %b want 1111", r_qf);
    end
  endtask

  task automatic test_reserved();
    issue(3'd3, 4'b0110, 4'd0);
    issue(3'd7, 4'b1111, 4'd5);
    n_tests++;
    if (r_done_cyc !== 1 || r_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rsvd_done_err: got cyc=%0d err=%b want 1 1", r_done_cyc, r_err);
    end
    n_tests++;
    if (r_drive !== 0 || r_qf !== 4'b0110) begin
      n_fail++;
      $display("FAIL rsvd_nodrive: got drv=%0d q=%b want 0 0110", r_drive, r_qf);
    end
  endtask

  task automatic test_toggle_hold();
    int dones = 0;
    int dcyc = -1;
    issue(3'd3, 4'b0101, 4'd0);
    cmd_valid = 1'b1; cmd = 3'd4; cmd_data = 4'b0110; cmd_steps = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) cmd_valid = 1'b0;
      if (done) begin dones++; dcyc = c; end
    end
    n_tests++;
    if (dones !== 1 || dcyc !== 3) begin
      n_fail++;
      $display("FAIL toggle_hold_once: got dones=%0d at %0d want 1 at 3", dones, dcyc);
    end
    n_tests++;
    if (q !== 4'b0011) begin
      n_fail++;
      $display("FAIL toggle_hold_q: got %b want 0011", q);
    end
  endtask

  task automatic test_reset_mid_apply();
    issue(3'd1, '0, 4'd0);
    cmd_valid = 1'b1; cmd = 3'd5; cmd_steps = 4'd5; cmd_data = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (j !== 4'b0011 || k !== 4'b0011) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got j=%b k=%b want 0011 0011", j, k);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (j !== '0 || k !== '0) begin
      n_fail++;
      $display("FAIL rst_async_jk: got j=%b k=%b want 0000 0000", j, k);
    end
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, done, wrap, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_hold: got r=%b d=%b w=%b e=%b want 1 0 0 0",
               cmd_ready, done, wrap, err);
    end
    rst = 1'b0;
    issue(3'd2, '0, 4'd0);
    n_tests++;
    if (r_done_cyc !== 3 || r_qf !== 4'b1111) begin
      n_fail++;
      $display("FAIL rst_then_set: got cyc=%0d q=%b want 3 1111", r_done_cyc, r_qf);
    end
  endtask

  task automatic test_back_to_back();
    issue(3'd2, '0, 4'd0);
    n_tests++;
    if (r_done_cyc !== 3 || r_ready_after !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got cyc=%0d rdy=%b want 3 1", r_done_cyc, r_ready_after);
    end
    issue(3'd4, 4'b0101, 4'd0);
    n_tests++;
    if (r_done_cyc !== 3 || r_qf !== 4'b1010) begin
      n_fail++;
      $display("FAIL b2b_second: got cyc=%0d q=%b want 3 1010", r_done_cyc, r_qf);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] mq;
    logic [2:0]   c;
    logic [W-1:0] d;
    int           s;
    issue(3'd1, '0, 4'd0);
    mq = '0;
    for (int it = 0; it < 40; it++) begin
      c = 3'($urandom);
      d = W'($urandom);
      s = $urandom_range(0, 5);
      issue(c, d, 4'(s));
      n_tests++;
      if (r_done_cyc !== m_cyc(c, s) || r_err !== (c == 3'd7)) begin
        n_fail++;
        $display("FAIL rand_done[%0d] op=%0d s=%0d: got cyc=%0d err=%b want %0d %b",
                 it, c, s, r_done_cyc, r_err, m_cyc(c, s), c == 3'd7);
      end
      n_tests++;
      if (r_wraps !== m_wraps(c, s, mq)) begin
        n_fail++;
        $display("FAIL rand_wrap[%0d] op=%0d s=%0d q0=%b: got %0d want %0d",
                 it, c, s, mq, r_wraps, m_wraps(c, s, mq));
      end
      n_tests++;
      if (r_drive !== m_drive(c, d, s)) begin
        n_fail++;
        $display("FAIL rand_drive[%0d] op=%0d: got %0d want %0d",
                 it, c, r_drive, m_drive(c, d, s));
      end
      mq = m_q(c, d, s, mq);
      n_tests++;
      if (r_qf !== mq || r_ready_after !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_q[%0d] op=%0d d=%b s=%0d: got q=%b rdy=%b want %b 1",
                 it, c, d, s, r_qf, r_ready_after, mq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_up_wrap();
    test_down_wrap();
    test_reserved();
    test_toggle_hold();
    test_reset_mid_apply();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
